// File: rtl/aes_128_pkg.sv
// Shared AES-128 constants and types: S-box, round constants, key-stream sizes and the
// key-expansion FSM state type.
package aes_128_pkg;

    localparam int unsigned NUM_RK  = 11;
    localparam int unsigned KEY_SET = 22;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [2:0] {
        StIdle,
        StLow,
        StHigh,
        StGap,
        StDone
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_128_key_expand_64_if.sv
// Key-load request and 64-bit round-key write stream. The expander uses the master view;
// whoever loads keys and consumes the stream uses the slave view.
interface aes_128_key_expand_64_if;

    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         en_wr;
    logic [63:0]  key_round_wr;
    logic         exp_done;

    modport master (
        input  key_in,
        input  key_load,
        output busy,
        output en_wr,
        output key_round_wr,
        output exp_done
    );

    modport slave (
        output key_in,
        output key_load,
        input  busy,
        input  en_wr,
        input  key_round_wr,
        input  exp_done
    );

endinterface

// File: rtl/aes_128_sub_word.sv
// AES SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_128_sub_word
    import aes_128_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};

endmodule

// File: rtl/aes_128_key_expand_64.sv
// AES-128 key expander streaming 11 round keys as 22 x 64-bit beats (low half first).
// Define AES_KEY_SBOX_PIPE_EN to register SubWord in LOW, taking the S-box out of the rk loop.
module aes_128_key_expand_64
    import aes_128_pkg::*;
#(
    parameter int unsigned GAP = 0
) (
    input  logic                           clk,
    input  logic                           kill,
    aes_128_key_expand_64_if.master        bus
);

    localparam logic [3:0] LastRnd = 4'(NUM_RK - 1);
    localparam logic [2:0] GapLast = 3'(GAP - 1);

    state_e       state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [2:0]   gap_q, gap_d;
    logic [63:0]  hold_q, hold_d;

    logic [31:0]  sw_in, sw_out, sw_use, t;
    logic [31:0]  n0, n1, n2, n3;

    assign sw_in = {rk_q[23:0], rk_q[31:24]};

    aes_128_sub_word u_sub_word (
        .word (sw_in),
        .sub  (sw_out)
    );

`ifdef AES_KEY_SBOX_PIPE_EN
    // rk is stable across LOW->HIGH, so SubWord captured in LOW is valid for HIGH's update.
    logic [31:0] sw_q;

    always_ff @(posedge clk) begin
        if (kill) begin
            sw_q <= '0;
        end else if (state_q == StLow) begin
            sw_q <= sw_out;
        end
    end

    assign sw_use = sw_q;
`else
    assign sw_use = sw_out;
`endif

    assign t  = sw_use ^ {rcon_q, 24'h0};
    assign n0 = rk_q[127:96] ^ t;
    assign n1 = rk_q[95:64] ^ n0;
    assign n2 = rk_q[63:32] ^ n1;
    assign n3 = rk_q[31:0] ^ n2;

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        rnd_d   = rnd_q;
        rcon_d  = rcon_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.key_load) begin
                    rk_d    = bus.key_in;
                    rnd_d   = '0;
                    rcon_d  = RCON[0];
                    gap_d   = '0;
                    state_d = StLow;
                end
            end
            StLow: state_d = StHigh;
            StHigh: begin
                // Keep the high half on the bus once the beat is over.
                hold_d = rk_q[127:64];
                if (rnd_q == LastRnd) begin
                    state_d = StDone;
                end else begin
                    rk_d    = {n0, n1, n2, n3};
                    rcon_d  = xtime(rcon_q);
                    rnd_d   = rnd_q + 4'd1;
                    gap_d   = '0;
                    state_d = (GAP > 0) ? StGap : StLow;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StLow;
                end else begin
                    gap_d = gap_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            state_q <= StIdle;
            rk_q    <= '0;
            rnd_q   <= '0;
            rcon_q  <= '0;
            gap_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            rnd_q   <= rnd_d;
            rcon_q  <= rcon_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.en_wr        = (state_q == StLow) || (state_q == StHigh);
    assign bus.busy         = bus.en_wr || (state_q == StGap);
    assign bus.exp_done     = (state_q == StDone);
    assign bus.key_round_wr = (state_q == StLow)  ? rk_q[63:0]   :
                              (state_q == StHigh) ? rk_q[127:64] : hold_q;

endmodule
